if_id_skid_buffer: RTL and testbench
====================================

IF_ID_SKID_BUFFER -- requirements
Module: if_id_skid_buffer

Interface
REQ-001 Parameter NOP_INSTR, default 32'h00000000, instruction presented on instr_o whenever valid_o is 0.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 valid_i  input  1  fetch stage offers pc_i/instr_i this cycle.
REQ-005 ready_o  output  1  buffer accepts an offered entry this cycle.
REQ-006 pc_i  input  32  PC+4 of the fetched instruction, from the program counter path.
REQ-007 instr_i  input  32  fetched instruction word from instruction memory.
REQ-008 valid_o  output  1  head entry valid for decode.
REQ-009 ready_i  input  1  decode stage consumes head entry this cycle; 0 = stall.
REQ-010 pc_o  output  32  PC+4 of head entry.
REQ-011 instr_o  output  32  instruction of head entry.
REQ-012 flush_i  input  1  branch/jump taken; discard all held and offered entries.

Function
REQ-013 Block SHALL hold 0, 1 or 2 entries (states EMPTY, ONE, FULL) in FIFO order; each entry = {pc, instr}.
REQ-014 Push SHALL occur when valid_i & ready_o & ~flush_i; pop SHALL occur when valid_o & ready_i.
REQ-015 ready_o SHALL equal ~rst_i & (state != FULL), combinational from state only (no path from ready_i).
REQ-016 valid_o SHALL equal (state != EMPTY).
REQ-017 When valid_o=1, pc_o/instr_o SHALL present the oldest entry; when valid_o=0, pc_o SHALL be 32'h0 and instr_o SHALL be NOP_INSTR.
REQ-018 Latency: entry pushed at edge N SHALL be on outputs immediately after edge N if the buffer was EMPTY or the only entry popped at edge N.
REQ-019 Transitions without flush: EMPTY --push--> ONE; ONE --push&~pop--> FULL; ONE --pop&~push--> EMPTY; ONE --push&pop--> ONE (new entry becomes head); FULL --pop--> ONE (second entry becomes head); otherwise hold.
REQ-020 In FULL no push SHALL occur; held entries SHALL remain bit-stable while ready_i=0.
REQ-021 flush_i=1 SHALL force next state EMPTY, overriding any push or pop in the same cycle; offered entry SHALL be dropped.
REQ-022 flush_i while EMPTY SHALL be a no-op; no entry SHALL be lost or duplicated across any push/pop/flush combination.
REQ-023 Data written into storage SHALL be captured unmodified (no width change, no arithmetic on pc_i).

Reset
REQ-024 rst_i=1 at a rising edge SHALL force state EMPTY, clear both storage slots to {32'h0, NOP_INSTR}, regardless of valid_i, ready_i, flush_i.
REQ-025 While rst_i=1, ready_o SHALL be 0 and valid_o SHALL be 0; first push allowed in cycle after rst_i deasserts.
REQ-026 Reset asserted mid-operation (ONE or FULL) SHALL discard all entries with no output of stale data afterward.

Verification
REQ-027 Reset then idle: rst_i=1 two cycles -> valid_o=0, ready_o=0, pc_o=0, instr_o=NOP_INSTR; rst_i=0 -> ready_o=1.
REQ-028 Streaming: ready_i=1, push pc 4,8,12 with instr A,B,C on consecutive cycles -> valid_o=1 each following cycle, outputs (4,A),(8,B),(12,C) in order, state never FULL.
REQ-029 Stall/fill: ready_i=0, push (4,A),(8,B),(12,C) -> after 2 pushes ready_o=0, (12,C) not accepted; outputs held at (4,A); ready_i=1 -> (4,A) then (8,B), ready_o returns 1 after first pop.
REQ-030 Flush priority: FULL with (4,A),(8,B), same cycle valid_i=1 (12,C), ready_i=1, flush_i=1 -> next cycle valid_o=0, ready_o=1, pc_o=0, instr_o=NOP_INSTR; nothing of (4,A),(8,B),(12,C) appears later.
REQ-031 ONE push&pop: holding (4,A), valid_i=1 (8,B), ready_i=1 -> next cycle outputs (8,B), state ONE, ready_o=1.
REQ-032 Reset mid-operation: FULL with (4,A),(8,B), rst_i=1 one cycle -> valid_o=0; after rst_i=0 with no push, valid_o stays 0.

Source files
------------

// File: rtl/if_id_skid_buffer.sv
// Two-entry IF/ID skid buffer between fetch and decode.
// Entries are {pc, instr} pairs and leave in FIFO order; flush_i discards everything held or offered.
module if_id_skid_buffer #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  input  logic        flush_i
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{pc: 32'h0, instr: NOP_INSTR};

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  entry_t in_entry;
  logic   push;
  logic   pop;

  // Handshake outputs depend only on state and reset, so ready_i never reaches ready_o.
  assign ready_o  = ~rst_i & (state_q != ST_FULL);
  assign valid_o  = ~rst_i & (state_q != ST_EMPTY);
  assign pc_o     = valid_o ? head_q.pc    : 32'h0;
  assign instr_o  = valid_o ? head_q.instr : NOP_INSTR;

  assign in_entry = '{pc: pc_i, instr: instr_i};
  assign push     = valid_i & ready_o & ~flush_i;
  assign pop      = valid_o & ready_i;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            head_d  = in_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_d = in_entry;
          end else if (push) begin
            tail_d  = in_entry;
            state_d = ST_FULL;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // The second entry slides into the head slot; nothing can be pushed while full.
          if (pop) begin
            head_d  = tail_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state_q <= ST_EMPTY;
      // NOTE: the storage slots are reset too, so a stale entry can never resurface after reset.
      head_q  <= RESET_ENTRY;
      tail_q  <= RESET_ENTRY;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Bench for if_id_skid_buffer: directed scenarios, then random traffic, all checked
// against a queue-based model of a two-deep FIFO with flush and reset.
module tb_if_id_skid_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] IA  = 32'hAAAA_0001;
  localparam logic [31:0] IB  = 32'hBBBB_0002;
  localparam logic [31:0] IC  = 32'hCCCC_0003;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] pc_i = 32'h0;
  logic [31:0] instr_i = 32'h0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        flush_i = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [63:0] model_q[$];

  if_id_skid_buffer #(.NOP_INSTR(NOP)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .pc_i    (pc_i),
    .instr_i (instr_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .pc_o    (pc_o),
    .instr_o (instr_o),
    .flush_i (flush_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, compare outputs mid-cycle against the model, then advance the model.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic rdy, input logic fl, input logic rs);
    logic        exp_valid;
    logic        exp_ready;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [63:0] head;
    valid_i = v;
    pc_i    = pc;
    instr_i = ins;
    ready_i = rdy;
    flush_i = fl;
    rst_i   = rs;
    @(negedge clk_i);
    exp_valid = !rs && (model_q.size() != 0);
    exp_ready = !rs && (model_q.size() < 2);
    head      = exp_valid ? model_q[0] : {32'h0, NOP};
    exp_pc    = head[63:32];
    exp_instr = head[31:0];
    check("valid_o", {31'b0, valid_o}, {31'b0, exp_valid});
    check("ready_o", {31'b0, ready_o}, {31'b0, exp_ready});
    check("pc_o",    pc_o,    exp_pc);
    check("instr_o", instr_o, exp_instr);
    if (rs || fl) begin
      model_q.delete();
    end else begin
      if (exp_valid && rdy) void'(model_q.pop_front());
      if (v && exp_ready) model_q.push_back({pc, ins});
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset, then idle.
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h4, IA,    1'b1, 1'b1, 1'b1);
    idle(1'b0);

    // Streaming with decode always ready.
    step(1'b1, 32'd4,  IA, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'd8,  IB, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'd12, IC, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Stall and fill: third offer is refused until a pop frees a slot.
    step(1'b1, 32'd4,  IA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'd8,  IB, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'd12, IC, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'd12, IC, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush beats a simultaneous push and pop while full.
    step(1'b1, 32'd4,  IA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'd8,  IB, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'd12, IC, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);

    // Push and pop together while holding one entry.
    step(1'b1, 32'd4, IA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'd8, IB, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);

    // Reset while full discards both entries.
    step(1'b1, 32'd4, IA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'd8, IB, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, $urandom, $urandom, ($urandom % 3) != 0,
           ($urandom % 16) == 0, ($urandom % 64) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
